i2s_sample_fifo: RTL
====================

Name: i2s_sample_fifo

Overview:
- Stereo sample buffer that sits directly upstream of the I2S transmitter.
- CPU/bus side pushes left/right sample pairs with a valid/ready handshake.
- Serializer side pulls one pair per audio frame with a single-cycle request and gets stable parallel words back.
- Handles underrun deterministically, and exposes fill level plus a low-water flag for interrupt generation.

Parameters:
- WIDTH, 16, bits per channel sample.
- DEPTH, 16, stereo pairs stored; must be a power of 2, >= 2.
- LOW_WATER, 4, low_water asserts while level < LOW_WATER.
- UNDERRUN_ZERO, 1, 1 = output zeros on underrun; 0 = hold last delivered pair.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous discard of all buffered samples.
- wr_valid  in  1  write request.
- wr_ready  out  1  FIFO can accept a pair (not full).
- wr_left  in  WIDTH  left sample to push.
- wr_right  in  WIDTH  right sample to push.
- rd_req  in  1  one-cycle pulse from serializer at frame start.
- rd_left  out  WIDTH  left sample for the current frame, registered.
- rd_right  out  WIDTH  right sample for the current frame, registered.
- rd_ack  out  1  one-cycle pulse: rd_left/rd_right updated.
- level  out  $clog2(DEPTH)+1  pairs currently stored, 0..DEPTH.
- low_water  out  1  level < LOW_WATER.
- underrun  out  1  sticky: a rd_req arrived while empty.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Storage: DEPTH x 2*WIDTH array.
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; index uses the low bits.
  - level = wr_ptr - rd_ptr, modulo arithmetic; full = level==DEPTH; empty = level==0.
  - Pointers wrap naturally.
- Reset, rst=1 at a clock edge:
  - Pointers 0; rd_left=rd_right=0; rd_ack=0; underrun=0.
  - wr_ready=1, level=0, low_water=(LOW_WATER>0).
  - Array contents don't care. Reset wins over every other input.
- Write: a push occurs on a clk edge with wr_valid & wr_ready.
  - The pair is stored at wr_ptr and wr_ptr increments.
  - A write while full (wr_ready=0) is ignored with no side effect.
  - wr_ready is combinational from full only, never from wr_valid.
- Read: latency 1.
  - If rd_req is high at edge N and the FIFO is not empty, the head pair loads into rd_left/rd_right at edge N, rd_ptr increments, and rd_ack is high for the cycle after N.
  - If rd_req arrives while empty:
    - rd_left/rd_right load 0 when UNDERRUN_ZERO=1, otherwise they hold.
    - rd_ack still pulses, so the serializer always gets a frame.
    - underrun sets.
  - rd_req held high for several cycles is treated as one request per cycle; the serializer guarantees single-cycle pulses.
- Simultaneous write and read, same edge:
  - Both pointers move and level is unchanged.
  - When empty, the read sees the pre-edge state: underrun is taken, the written pair is stored, and level becomes 1. There is no bypass path.
  - When full, wr_ready=0 so only the read occurs.
- Flush at an edge:
  - rd_ptr <= wr_ptr' where wr_ptr' = wr_ptr, i.e. the FIFO empties.
  - A concurrent write is dropped.
  - A concurrent rd_req is treated as an underrun read: zero/hold, rd_ack pulses, and underrun sets.
  - rd_left/rd_right are otherwise unchanged.
- underrun:
  - Set has priority over underrun_clr on the same edge.
  - Cleared only by underrun_clr or rst.
- level and low_water are registered from pointer state and update the cycle after the causing edge.

Test Plan:
- Reset then idle -> level=0, wr_ready=1, low_water=1, underrun=0, rd_left=rd_right=0.
- Push pairs (0x1111,0x2222),(0x3333,0x4444), then two rd_req pulses 10 cycles apart -> each rd_ack is one cycle after its req with values in order; level goes 2→1→0.
- Push DEPTH=16 pairs -> wr_ready=0 after the 16th. A 17th write with value 0xDEAD is ignored. Sixteen reads return pairs in order with no 0xDEAD; pointers wrap on the next fill without corruption.
- rd_req while empty, UNDERRUN_ZERO=1 -> rd_left=rd_right=0, rd_ack pulses, underrun=1. Underrun_clr held on the same edge as a second empty read -> underrun stays 1; a later underrun_clr alone clears it.
- Simultaneous wr_valid and rd_req on an empty FIFO -> underrun set, level=1, the next rd_req returns the written pair.
- Fill 5, flush asserted with a concurrent write -> level=0, the written pair is dropped, and low_water=1 on the following cycle.

Source files
------------

// File: rtl/i2s_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : i2s_sample_fifo
// Purpose  : Stereo sample buffer feeding the I2S transmitter. The bus side
//            pushes left/right pairs with valid/ready. The serializer pulls
//            one pair per frame with a single-cycle request and receives
//            registered parallel words one cycle later. Underrun is handled
//            deterministically: the serializer still gets a frame. Fill level
//            and a low-water flag are exported for interrupt generation.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            flush             - discard all buffered pairs
//            wr_valid/wr_ready - push handshake (ready = not full)
//            wr_left/wr_right  - pair to push
//            rd_req            - frame-start pull request (one-cycle pulse)
//            rd_left/rd_right  - registered pair for the current frame
//            rd_ack            - pulse: rd_left/rd_right were just updated
//            level             - pairs stored, 0..DEPTH (registered)
//            low_water         - level < LOW_WATER (registered)
//            underrun          - sticky: a read arrived while empty
//            underrun_clr      - clears underrun (set wins on same edge)
// Revision : 1.0 - initial release
// ============================================================================
module i2s_sample_fifo #(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 16,
    parameter int LOW_WATER     = 4,
    parameter int UNDERRUN_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH-1:0]         wr_left,
    input  logic [WIDTH-1:0]         wr_right,
    input  logic                     rd_req,
    output logic [WIDTH-1:0]         rd_left,
    output logic [WIDTH-1:0]         rd_right,
    output logic                     rd_ack,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     low_water,
    output logic                     underrun,
    input  logic                     underrun_clr
);

    localparam int          c_AW        = $clog2(DEPTH);
    localparam int          c_PW        = c_AW + 1;
    localparam logic [31:0] c_LOW_WATER = LOW_WATER;
    localparam logic [c_PW-1:0] c_DEPTH = c_PW'(DEPTH);

    // Storage: each entry holds {left, right}.
    logic [2*WIDTH-1:0] r_mem [DEPTH];

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW-1:0]  w_wr_ptr_nxt;
    logic [c_PW-1:0]  w_rd_ptr_nxt;
    logic [c_PW-1:0]  w_level_cur;
    logic [c_PW-1:0]  w_level_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_under_rd;
    logic             w_low_nxt;
    logic [2*WIDTH-1:0] w_head;
    logic [WIDTH-1:0] w_under_left;
    logic [WIDTH-1:0] w_under_right;

    logic [WIDTH-1:0] r_rd_left;
    logic [WIDTH-1:0] r_rd_right;
    logic             r_rd_ack;
    logic [c_PW-1:0]  r_level;
    logic             r_low_water;
    logic             r_underrun;

    // Occupancy from live pointers; drives the handshake without delay.
    assign w_level_cur = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_level_cur == c_DEPTH);
    assign w_empty     = (w_level_cur == '0);
    assign wr_ready    = ~w_full;

    // A flush discards the concurrent write and turns any concurrent read
    // into an underrun read, since the buffer is being emptied on this edge.
    assign w_push     = wr_valid & ~w_full & ~flush;
    assign w_pop      = rd_req & ~w_empty & ~flush;
    assign w_under_rd = rd_req & (w_empty | flush);

    assign w_wr_ptr_nxt = r_wr_ptr + c_PW'(w_push);
    assign w_rd_ptr_nxt = flush ? r_wr_ptr : (r_rd_ptr + c_PW'(w_pop));
    assign w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_low_nxt    = ({{(32-c_PW){1'b0}}, w_level_nxt} < c_LOW_WATER);

    assign w_head = r_mem[r_rd_ptr[c_AW-1:0]];

    // Data presented to the serializer when a read finds nothing buffered.
    generate
        if (UNDERRUN_ZERO != 0) begin : g_underrun_zero
            assign w_under_left  = '0;
            assign w_under_right = '0;
        end else begin : g_underrun_hold
            assign w_under_left  = r_rd_left;
            assign w_under_right = r_rd_right;
        end
    endgenerate

    // Array write; contents are not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {wr_left, wr_right};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_left   <= '0;
            r_rd_right  <= '0;
            r_rd_ack    <= 1'b0;
            r_level     <= '0;
            r_low_water <= (LOW_WATER > 0);
            r_underrun  <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_level     <= w_level_nxt;
            r_low_water <= w_low_nxt;
            // Every request gets a frame, buffered or not.
            r_rd_ack    <= rd_req;

            if (w_pop) begin
                r_rd_left  <= w_head[2*WIDTH-1:WIDTH];
                r_rd_right <= w_head[WIDTH-1:0];
            end else if (w_under_rd) begin
                r_rd_left  <= w_under_left;
                r_rd_right <= w_under_right;
            end

            // Setting takes priority over a same-edge clear.
            if (w_under_rd) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign rd_left   = r_rd_left;
    assign rd_right  = r_rd_right;
    assign rd_ack    = r_rd_ack;
    assign level     = r_level;
    assign low_water = r_low_water;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire
